// File: rtl/dom_output_mul_stage.sv
// dom_output_mul_stage: masked DOM-indep GF(2^4) products of the inverter output with the mapped S-box input nibbles
module dom_output_mul_stage #(
  parameter int SHARES = 2,
  parameter int INV_LATENCY = 3
) (
  input  logic                              ClkxCI,
  input  logic                              RstxBI,
  input  logic                              ValidxSI,
  input  logic [4*SHARES-1:0]               _AhxDI,
  input  logic [4*SHARES-1:0]               _AlxDI,
  input  logic [4*SHARES-1:0]               _InvxDI,
  input  logic [2*SHARES*(SHARES-1)-1:0]    _Zmul4xDI,
  input  logic [2*SHARES*(SHARES-1)-1:0]    _Zmul5xDI,
  output logic [8*SHARES-1:0]               _QxDO,
  output logic                              ValidxSO
);
  localparam int NW = 4*SHARES;

  function automatic logic [1:0] gf2Mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] gf2ScaleN(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic logic [3:0] gf4Mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] e;
    e = gf2ScaleN(gf2Mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {gf2Mul(x[3:2], y[3:2]) ^ e, gf2Mul(x[1:0], y[1:0]) ^ e};
  endfunction

  function automatic int pairIdx(input int a, input int b);
    int p;
    p = 0;
    for (int k = 0; k < a; k++) p += SHARES - 1 - k;
    return p + b - a - 1;
  endfunction

  logic [NW-1:0] ahD, alD;
  logic vD, v1;
  logic [4*SHARES*SHARES-1:0] t4All, t5All;
  logic [8*SHARES-1:0] qNext;

  if (INV_LATENCY == 0) begin : gNoDly
    assign ahD = _AhxDI;
    assign alD = _AlxDI;
    assign vD = ValidxSI;
  end else begin : gDly
    logic [NW-1:0] ahSr [INV_LATENCY];
    logic [NW-1:0] alSr [INV_LATENCY];
    logic vSr [INV_LATENCY];
    // free-running shift so the nibbles line up with the inverter result
    always_ff @(posedge ClkxCI) begin
      if (!RstxBI) begin
        for (int k = 0; k < INV_LATENCY; k++) begin
          ahSr[k] <= '0;
          alSr[k] <= '0;
          vSr[k] <= 1'b0;
        end
      end else begin
        ahSr[0] <= _AhxDI;
        alSr[0] <= _AlxDI;
        vSr[0] <= ValidxSI;
        for (int k = 1; k < INV_LATENCY; k++) begin
          ahSr[k] <= ahSr[k-1];
          alSr[k] <= alSr[k-1];
          vSr[k] <= vSr[k-1];
        end
      end
    end
    assign ahD = ahSr[INV_LATENCY-1];
    assign alD = alSr[INV_LATENCY-1];
    assign vD = vSr[INV_LATENCY-1];
  end

  for (genvar i = 0; i < SHARES; i++) begin : gRow
    for (genvar j = 0; j < SHARES; j++) begin : gCol
      logic [3:0] t4r, t5r;
      if (i == j) begin : gInner
        // inner-domain products need no fresh mask
        always_ff @(posedge ClkxCI) begin
          t4r <= !RstxBI ? 4'h0 : gf4Mul(alD[4*i +: 4], _InvxDI[4*j +: 4]);
          t5r <= !RstxBI ? 4'h0 : gf4Mul(ahD[4*i +: 4], _InvxDI[4*j +: 4]);
        end
      end else begin : gCross
        localparam int P = (i < j) ? pairIdx(i, j) : pairIdx(j, i);
        // cross-domain products are masked and registered before any share mixing
        always_ff @(posedge ClkxCI) begin
          t4r <= !RstxBI ? 4'h0 : gf4Mul(alD[4*i +: 4], _InvxDI[4*j +: 4]) ^ _Zmul4xDI[4*P +: 4];
          t5r <= !RstxBI ? 4'h0 : gf4Mul(ahD[4*i +: 4], _InvxDI[4*j +: 4]) ^ _Zmul5xDI[4*P +: 4];
        end
      end
      assign t4All[4*(i*SHARES+j) +: 4] = t4r;
      assign t5All[4*(i*SHARES+j) +: 4] = t5r;
    end
  end

  // compress each share's registered terms into its output nibbles
  always_comb begin
    qNext = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        qNext[8*i+4 +: 4] = qNext[8*i+4 +: 4] ^ t4All[4*(i*SHARES+j) +: 4];
        qNext[8*i +: 4] = qNext[8*i +: 4] ^ t5All[4*(i*SHARES+j) +: 4];
      end
    end
  end

  // output register and valid tracking through both stages
  always_ff @(posedge ClkxCI) begin
    if (!RstxBI) begin
      _QxDO <= '0;
      v1 <= 1'b0;
      ValidxSO <= 1'b0;
    end else begin
      _QxDO <= qNext;
      v1 <= vD;
      ValidxSO <= v1;
    end
  end
endmodule

// File: tb/tb_dom_output_mul_stage.sv
// tb_dom_output_mul_stage: scoreboard bench for the masked output multiplier stage
module tb_dom_output_mul_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, v2, v3, vo2, vo3;
  logic [7:0] ah2, al2, inv2;
  logic [15:0] q2o;
  logic [11:0] ah3, al3, inv3, z4b, z5b;
  logic [23:0] q3o;
  logic [3:0] z4a, z5a;

  dom_output_mul_stage #(.SHARES(2), .INV_LATENCY(3)) dut2 (
    .ClkxCI(clk), .RstxBI(rstn), .ValidxSI(v2), ._AhxDI(ah2), ._AlxDI(al2), ._InvxDI(inv2),
    ._Zmul4xDI(z4a), ._Zmul5xDI(z5a), ._QxDO(q2o), .ValidxSO(vo2));

  dom_output_mul_stage #(.SHARES(3), .INV_LATENCY(0)) dut3 (
    .ClkxCI(clk), .RstxBI(rstn), .ValidxSI(v3), ._AhxDI(ah3), ._AlxDI(al3), ._InvxDI(inv3),
    ._Zmul4xDI(z4b), ._Zmul5xDI(z5b), ._QxDO(q3o), .ValidxSO(vo3));

  typedef struct {
    int cyc;
    logic [7:0] unm;
    bit exact;
    logic [15:0] full;
    bit vary;
  } exp_t;

  exp_t sb2[$], sb3[$];
  exp_t e2, e3;
  int cyc = 0, total = 0, bad = 0;
  bit rnd = 1'b1;
  logic [11:0] inv2Sched [4096];
  logic [11:0] inv3Sched [4096];
  logic [255:0] seen0 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, got, exp, cyc);
    end
  endtask

  function automatic logic [11:0] shareIt(input int n, input logic [3:0] u);
    logic [11:0] s;
    logic [3:0] acc, r;
    s = '0;
    acc = u;
    for (int k = 1; k < n; k++) begin
      r = rnd ? 4'($urandom) : 4'h0;
      s[4*k +: 4] = r;
      acc ^= r;
    end
    s[3:0] = acc;
    return s;
  endfunction

  task automatic step(input int d, input logic v, input logic [3:0] ah, input logic [3:0] al,
                      input logic [3:0] inv, input logic [7:0] expU, input bit exact,
                      input logic [15:0] full, input bit vary);
    logic [11:0] sa, sl, si;
    exp_t e;
    sa = shareIt(d, ah);
    sl = shareIt(d, al);
    si = shareIt(d, inv);
    v2 = (d == 2) && v;
    v3 = (d == 3) && v;
    if (d == 2) begin
      ah2 = sa[7:0];
      al2 = sl[7:0];
    end else begin
      ah3 = sa;
      al3 = sl;
    end
    if (v) begin
      e.cyc = cyc + ((d == 2) ? 5 : 2);
      e.unm = expU;
      e.exact = exact;
      e.full = full;
      e.vary = vary;
      if (d == 2) begin
        inv2Sched[cyc + 3] = si;
        sb2.push_back(e);
      end else begin
        inv3Sched[cyc] = si;
        sb3.push_back(e);
      end
    end
    inv2 = inv2Sched[cyc][7:0];
    inv3 = inv3Sched[cyc];
    z4a = rnd ? 4'($urandom) : 4'h0;
    z5a = rnd ? 4'($urandom) : 4'h0;
    z4b = rnd ? 12'($urandom) : 12'h0;
    z5b = rnd ? 12'($urandom) : 12'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(2, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 16'h0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (vo2) begin
      if (sb2.size() == 0) chk("dut2 valid with empty scoreboard", 32'(vo2), 0);
      else begin
        e2 = sb2.pop_front();
        chk("dut2 latency", cyc, e2.cyc);
        chk("dut2 unmasked", 32'(q2o[15:8] ^ q2o[7:0]), 32'(e2.unm));
        if (e2.exact) chk("dut2 shares", 32'(q2o), 32'(e2.full));
        if (e2.vary) seen0[q2o[7:0]] = 1'b1;
      end
    end
    if (vo3) begin
      if (sb3.size() == 0) chk("dut3 valid with empty scoreboard", 32'(vo3), 0);
      else begin
        e3 = sb3.pop_front();
        chk("dut3 latency", cyc, e3.cyc);
        chk("dut3 unmasked", 32'(q3o[23:16] ^ q3o[15:8] ^ q3o[7:0]), 32'(e3.unm));
      end
    end
  end

  initial begin
    rstn = 1'b0;
    {v2, v3} = 2'b00;
    {ah2, al2, inv2, z4a, z5a} = '0;
    {ah3, al3, inv3, z4b, z5b} = '0;
    for (int k = 0; k < 4096; k++) begin
      inv2Sched[k] = '0;
      inv3Sched[k] = '0;
    end
    rnd = 1'b1;
    idle(3);
    chk("reset q2", 32'(q2o), 0);
    chk("reset v2", 32'(vo2), 0);
    chk("reset q3", 32'(q3o), 0);
    chk("reset v3", 32'(vo3), 0);
    rstn = 1'b1;
    idle(2);
    rnd = 1'b0;
    step(2, 1'b1, 4'hF, 4'h5, 4'hF, 8'h5F, 1'b1, 16'h005F, 1'b0);
    idle(8);
    rnd = 1'b1;
    for (int k = 0; k < 4; k++)
      step(2, 1'b1, 4'($urandom), 4'($urandom), 4'h0, 8'h00, 1'b0, 16'h0, 1'b0);
    idle(8);
    for (int k = 0; k < 16; k++) step(2, 1'b1, 4'h9, 4'h6, 4'hF, 8'h69, 1'b0, 16'h0, 1'b1);
    idle(8);
    chk("mask shares vary", 32'($countones(seen0) > 1), 1);
    for (int k = 0; k < 16; k++) step(2, 1'b1, 4'hF, 4'(k), 4'hF, {4'(k), 4'hF}, 1'b0, 16'h0, 1'b0);
    idle(8);
    step(2, 1'b1, 4'h3, 4'hA, 4'hF, 8'hA3, 1'b0, 16'h0, 1'b0);
    step(2, 1'b1, 4'h7, 4'hC, 4'hF, 8'hC7, 1'b0, 16'h0, 1'b0);
    rstn = 1'b0;
    idle(1);
    chk("midreset q2", 32'(q2o), 0);
    chk("midreset v2", 32'(vo2), 0);
    sb2.delete();
    rstn = 1'b1;
    idle(10);
    for (int k = 0; k < 16; k++) step(3, 1'b1, 4'h9, 4'h6, 4'hF, 8'h69, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 2; k++)
      step(3, 1'b1, 4'($urandom), 4'($urandom), 4'h0, 8'h00, 1'b0, 16'h0, 1'b0);
    idle(8);
    chk("dut2 pending", sb2.size(), 0);
    chk("dut3 pending", sb3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dom_output_mul_stage.md
Name: dom_output_mul_stage

Overview:
- Final nonlinear stage of the masked DOM AES S-box. It sits directly downstream of the shared GF(2^4) inverter.
- It computes the two masked GF(2^4) products of the inverter output with the high and low nibbles of the S-box input. Both nibbles arrive already mapped to the normal basis.
- It delays the input nibbles internally so that they meet the inverter result. It outputs an 8-bit shared value in the normal basis plus a valid flag.
- The inverse basis change and affine map stay in the downstream linear block.

Parameters:
- SHARES, 2: number of masking shares (d+1), valid range 2..4.
- INV_LATENCY, 3: cycles from the inverter input to its output. The nibble delay line uses this depth; the range is 0..8.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, synchronous, active-low.
- ValidxSI  in  1  marks that _AhxDI/_AlxDI carry a new S-box input this cycle.
- _AhxDI  in  4*SHARES  high nibble of the mapped input; share i is at [4i+3:4i].
- _AlxDI  in  4*SHARES  low nibble of the mapped input; same layout as _AhxDI.
- _InvxDI  in  4*SHARES  inverter output; it arrives INV_LATENCY cycles after the matching _AhxDI/_AlxDI.
- _Zmul4xDI  in  2*SHARES*(SHARES-1)  fresh randomness for the Inv·Al multiplier.
- _Zmul5xDI  in  2*SHARES*(SHARES-1)  fresh randomness for the Inv·Ah multiplier.
- _QxDO  out  8*SHARES  result; share i has the high nibble at [8i+7:8i+4] and the low nibble at [8i+3:8i].
- ValidxSO  out  1  marks that _QxDO holds a new result.

Behaviour:
- Reset: when RstxBI=0 at a rising edge, every register clears to 0 on that edge. This covers the delay line, the stage-1 products, _QxDO and ValidxSO.
  - A reset mid-operation discards all in-flight data.
  - ValidxSO stays 0 until INV_LATENCY+2 cycles after the first post-reset ValidxSI.
- Delay line: _AhxDI, _AlxDI and ValidxSI each pass through an INV_LATENCY-deep shift register with no enable. The register shifts every cycle. With INV_LATENCY=0 the signals pass straight through as wires.
- GF(2^4) multiply: use the codebase's normal-basis multiplier (the same basis as the inverter).
  - The element 4'b1111 is the multiplicative one; 4'b0000 is zero.
  - Multiplication is commutative.
- DOM-indep multiplier: one per product, with A = delayed Al or Ah and B = Inv.
- Randomness layout: unordered share pairs (i<j) are enumerated lexicographically as p = 0..SHARES*(SHARES-1)/2-1.
  - Pair p uses Z[4p+3:4p].
  - _Zmul4xDI[4p+3:4p] feeds the Inv·Al multiplier; the same slice of _Zmul5xDI feeds Inv·Ah.
- Stage 1 (registered), sampled in the cycle _InvxDI is valid:
  - inner term: Ti_i = A_i·B_i.
  - cross terms, for each j≠i: Ti_j = A_i·B_j + Z_p, where p is the index of pair {i,j}.
  - Each Z is used exactly once in share i's term and once in share j's term.
  - Every cross term is registered before it is combined. No combinational path may mix different share domains.
- Stage 2 (registered output):
  - Q_i high = XOR over all j of Ti_j from the Inv·Al multiplier.
  - Q_i low = XOR over all j of Ti_j from the Inv·Ah multiplier.
- Latency and throughput:
  - _InvxDI/Z to _QxDO: 2 cycles.
  - ValidxSI to ValidxSO: INV_LATENCY+2 cycles.
  - One new input is accepted per cycle. There is no backpressure and no stall.
- Idle cycles (ValidxSI=0): the datapath still computes and _QxDO may change. Consumers must qualify _QxDO with ValidxSO.
- Unmasking invariant: XOR over shares of _QxDO = {inv·al, inv·ah} of the unshared values, for any Z.

Test Plan:
- Reset with SHARES=2, INV_LATENCY=3, Z=0, then drive Ah=1111/0000, Al=0101/0000 with ValidxSI=1 for one cycle. Three cycles later drive Inv=1111/0000. Required: ValidxSO=1 exactly 5 cycles after ValidxSI, and _QxDO share0=0101_1111, share1=0000_0000.
- Zero annihilation: unshared Inv=0000 with arbitrary Ah/Al and random Z. Required: the XOR of the shares of _QxDO = 8'h00 on the ValidxSO cycle.
- Mask independence: split a fixed unshared input (inv=1111, al=0110, ah=1001) into 16 random sharings with random Z. Required: the unmasked _QxDO = 0110_1001 every time, while individual shares vary.
- Streaming: apply ValidxSI back-to-back for 16 cycles, stepping Al through 0..15 with Inv=1111 and Ah=1111. Required: 16 consecutive ValidxSO cycles, with unmasked low nibble = 1111 and high nibble = 0..15 in order.
- Reset mid-stream: assert RstxBI=0 for one cycle two cycles after the first ValidxSI. Required: _QxDO=0 and ValidxSO=0 on the following cycle, and no ValidxSO pulse for the flushed inputs.
- SHARES=3, INV_LATENCY=0: repeat scenario 3 using 12-bit Z buses. Required: unmasked results match, with a ValidxSI→ValidxSO latency of 2.
